commit_checker: RTL and testbench
=================================

COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000: PC expected on the first commit after reset.
REQ-002 Parameter WDOG_LIMIT, default 1000: maximum number of consecutive cycles allowed without a commit.
REQ-003 Parameter HALT_INSTR, default 32'h0010_0073 (ebreak): instruction that ends the run.
REQ-004 clk  in  1  clock; the block uses this single clock.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 commit  in  1  one instruction retires this cycle.
REQ-007 commit_instr  in  32  retired instruction word.
REQ-008 commit_pc  in  64  PC of the retired instruction.
REQ-009 commit_pre_pc  in  64  architectural next PC of the retired instruction.
REQ-010 halt_code  in  64  value of x10/a0, sampled on the halt commit.
REQ-011 done  out  1  run ended: good, bad or error.
REQ-012 good  out  1  run ended through HALT_INSTR with halt_code == 0.
REQ-013 err  out  1  checker detected an error.
REQ-014 err_code  out  2  error cause: 0 none, 1 PC mismatch, 2 watchdog timeout.
REQ-015 err_pc  out  64  commit_pc captured on a mismatch.
REQ-016 err_expect_pc  out  64  expected PC at the mismatch or timeout.
REQ-017 instret  out  64  number of accepted commits.
REQ-018 cycles  out  64  number of cycles spent in RUN.

Function
REQ-019 FSM SHALL have the states RUN, GOOD, BAD and ERR; reset SHALL enter RUN.
REQ-020 A register expect_pc SHALL hold the expected next commit PC; reset SHALL load it with RESET_PC.
REQ-021 In RUN, a commit with commit_pc == expect_pc SHALL increment instret and load expect_pc with commit_pre_pc on the next edge.
REQ-022 In RUN, a commit with commit_pc != expect_pc SHALL go to ERR with err_code=1, capture err_pc=commit_pc and err_expect_pc=expect_pc, and leave instret unchanged.
REQ-023 In RUN, a matching commit with commit_instr == HALT_INSTR SHALL count in instret, then go to GOOD if halt_code == 0, otherwise BAD.
REQ-024 If a halt commit also mismatches its PC, the mismatch SHALL win and the FSM SHALL go to ERR.
REQ-025 cycles SHALL increment on every RUN cycle and freeze in GOOD, BAD and ERR.
REQ-026 instret and cycles SHALL wrap modulo 2^64 without any flag.
REQ-027 GOOD, BAD and ERR SHALL be terminal until rst; commits in these states SHALL be ignored, and all outputs SHALL hold.
REQ-028 Outputs SHALL be registered: done = state != RUN, good = (state == GOOD), err = (state == ERR); each is visible one cycle after the triggering commit.

Reset
REQ-029 On rst, the block SHALL go to RUN with expect_pc=RESET_PC and clear all outputs and counters to 0, including done, good, err, err_code, err_pc, err_expect_pc, instret and cycles.
REQ-030 rst asserted in any state, including mid-run, SHALL take priority over a commit in the same cycle.

Configuration
REQ-031 With COMMIT_CHECK_WDOG_EN defined, a counter SHALL clear on each commit and increment on each RUN cycle without a commit.
REQ-032 With COMMIT_CHECK_WDOG_EN defined, when the counter reaches WDOG_LIMIT the FSM SHALL go to ERR with err_code=2 and err_expect_pc=expect_pc.
REQ-033 With COMMIT_CHECK_WDOG_EN defined, a commit in the expiry cycle SHALL win: the counter clears and no timeout occurs.
REQ-034 Without COMMIT_CHECK_WDOG_EN, no watchdog logic SHALL exist and err_code SHALL never equal 2.

Structure
REQ-035 Package commit_checker_pkg SHALL hold the FSM state enum, the err_code constants (ERR_NONE, ERR_PC, ERR_WDOG) and the EBREAK_INSTR constant.
REQ-036 The watchdog SHALL be a sub-module commit_wdog (inputs: clk, rst, enable, kick; output: expired), instantiated only under COMMIT_CHECK_WDOG_EN.

Verification
REQ-037 Scenario: three commits with PCs 0x80000000/04/08 and pre_pc = PC+4 -> instret=3, err=0, expect_pc=0x8000000C.
REQ-038 Scenario: first commit with commit_pc=0x80000004 -> next cycle err=1, err_code=1, err_pc=0x80000004, err_expect_pc=0x80000000, done=1.
REQ-039 Scenario: ebreak commit at the expected PC with halt_code=0 -> good=1, done=1; with halt_code=5 -> good=0, done=1, err=0.
REQ-040 Scenario (WDOG_EN, WDOG_LIMIT=10): one commit, then 10 idle cycles -> err_code=2; a commit in the 10th idle cycle -> no error.
REQ-041 Scenario: after GOOD, a further mismatching commit -> outputs unchanged; then rst -> all outputs 0 and expect_pc=0x80000000.
REQ-042 Scenario: rst in the same cycle as a mismatching commit -> err stays 0.

Source files
------------

// File: rtl/commit_checker_pkg.sv
// Shared types and constants for the commit checker.
// FSM state encoding, error cause codes and the ebreak encoding.
package commit_checker_pkg;

    typedef enum logic [1:0] {
        RUN,
        GOOD,
        BAD,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_PC   = 2'd1;
    localparam logic [1:0] ERR_WDOG = 2'd2;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/commit_wdog.sv
// Commit watchdog: counts enabled cycles without a kick.
// expired pulses in the cycle the idle count reaches LIMIT; a kick wins.
module commit_wdog #(
    parameter int unsigned LIMIT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    logic [31:0] idleCount;

    assign expired = enable && !kick && (idleCount == LIMIT - 1);

    always_ff @(posedge clk) begin
        if (rst || kick) begin
            idleCount <= '0;
        end else if (enable) begin
            idleCount <= idleCount + 32'd1;
        end
    end

endmodule

// File: rtl/commit_checker.sv
// Retirement-stream checker: PC continuity, halt detection and counters.
// Define COMMIT_CHECK_WDOG_EN to add the no-commit watchdog.
module commit_checker
    import commit_checker_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int unsigned WDOG_LIMIT = 1000,
    parameter logic [31:0] HALT_INSTR = EBREAK_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [31:0] commit_instr,
    input  logic [63:0] commit_pc,
    input  logic [63:0] commit_pre_pc,
    input  logic [63:0] halt_code,
    output logic        done,
    output logic        good,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [63:0] err_pc,
    output logic [63:0] err_expect_pc,
    output logic [63:0] instret,
    output logic [63:0] cycles
);

    state_t      state;
    state_t      stateNext;
    logic [63:0] expectPc;
    logic        running;
    logic        pcMatch;
    logic        isHalt;
    logic        timeout;

    assign running = (state == RUN);
    assign pcMatch = (commit_pc == expectPc);
    assign isHalt  = (commit_instr == HALT_INSTR);

`ifdef COMMIT_CHECK_WDOG_EN
    logic wdogExpired;

    commit_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) uWdog (
        .clk    (clk),
        .rst    (rst),
        .enable (running),
        .kick   (commit),
        .expired(wdogExpired)
    );

    assign timeout = running && wdogExpired;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        if (running) begin
            if (commit) begin
                if (!pcMatch) begin
                    stateNext = ERR;
                end else if (isHalt) begin
                    stateNext = (halt_code == 64'd0) ? GOOD : BAD;
                end
            end else if (timeout) begin
                stateNext = ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            expectPc      <= RESET_PC;
            err_code      <= ERR_NONE;
            err_pc        <= '0;
            err_expect_pc <= '0;
            instret       <= '0;
            cycles        <= '0;
        end else begin
            state <= stateNext;
            if (running) begin
                cycles <= cycles + 64'd1;
                if (commit && pcMatch) begin
                    instret  <= instret + 64'd1;
                    expectPc <= commit_pre_pc;
                end else if (commit) begin
                    err_code      <= ERR_PC;
                    err_pc        <= commit_pc;
                    err_expect_pc <= expectPc;
                end else if (timeout) begin
                    err_code      <= ERR_WDOG;
                    err_expect_pc <= expectPc;
                end
            end
        end
    end

    // Status flags come straight from the state register.
    assign done = !running;
    assign good = (state == GOOD);
    assign err  = (state == ERR);

endmodule

// File: tb/tb_commit_checker.sv
// Scoreboard bench for commit_checker with a behavioural model.
// Honours COMMIT_CHECK_WDOG_EN to exercise the watchdog.
module tb_commit_checker;

    localparam logic [63:0] RPC  = 64'h8000_0000;
    localparam logic [31:0] HALT = 32'h0010_0073;
    localparam int          WLIM = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit = 1'b0;
    logic [31:0] commit_instr = '0;
    logic [63:0] commit_pc = '0;
    logic [63:0] commit_pre_pc = '0;
    logic [63:0] halt_code = '0;
    logic        done, good, err;
    logic [1:0]  err_code;
    logic [63:0] err_pc, err_expect_pc, instret, cycles;

    commit_checker #(
        .RESET_PC  (RPC),
        .WDOG_LIMIT(WLIM),
        .HALT_INSTR(HALT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .commit       (commit),
        .commit_instr (commit_instr),
        .commit_pc    (commit_pc),
        .commit_pre_pc(commit_pre_pc),
        .halt_code    (halt_code),
        .done         (done),
        .good         (good),
        .err          (err),
        .err_code     (err_code),
        .err_pc       (err_pc),
        .err_expect_pc(err_expect_pc),
        .instret      (instret),
        .cycles       (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        good;
        logic        err;
        logic [1:0]  code;
        logic [63:0] errPc;
        logic [63:0] errExp;
        logic [63:0] instret;
        logic [63:0] cycles;
    } exp_t;

    exp_t sb[$];
    int   nChecks = 0;
    int   nPass = 0;

    // Model: 0 running, 1 halted ok, 2 halted bad, 3 error
    int          mEnd = 0;
    logic [63:0] mExpect = RPC;
    logic [1:0]  mCode = 0;
    logic [63:0] mErrPc = 0, mErrExp = 0, mInstret = 0, mCycles = 0;
    int          mIdle = 0;

    task automatic step(input logic r, input logic c, input logic [31:0] ins,
                        input logic [63:0] pc, input logic [63:0] npc,
                        input logic [63:0] hc);
        exp_t e;
        @(negedge clk);
        rst = r; commit = c; commit_instr = ins;
        commit_pc = pc; commit_pre_pc = npc; halt_code = hc;
        if (r) begin
            mEnd = 0; mExpect = RPC; mCode = 0; mErrPc = 0;
            mErrExp = 0; mInstret = 0; mCycles = 0; mIdle = 0;
        end else if (mEnd == 0) begin
            mCycles++;
            if (c) begin
                mIdle = 0;
                if (pc != mExpect) begin
                    mEnd = 3; mCode = 1; mErrPc = pc; mErrExp = mExpect;
                end else begin
                    mInstret++;
                    mExpect = npc;
                    if (ins == HALT) mEnd = (hc == 0) ? 1 : 2;
                end
            end else begin
                mIdle++;
`ifdef COMMIT_CHECK_WDOG_EN
                if (mIdle == WLIM) begin
                    mEnd = 3; mCode = 2; mErrExp = mExpect;
                end
`endif
            end
        end
        e.done = (mEnd != 0); e.good = (mEnd == 1); e.err = (mEnd == 3);
        e.code = mCode; e.errPc = mErrPc; e.errExp = mErrExp;
        e.instret = mInstret; e.cycles = mCycles;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ok(input logic [63:0] pc, input logic [31:0] ins,
                      input logic [63:0] hc);
        step(0, 1, ins, pc, pc + 64'd4, hc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                nChecks++;
                if (done === e.done && good === e.good && err === e.err &&
                    err_code === e.code && err_pc === e.errPc &&
                    err_expect_pc === e.errExp && instret === e.instret &&
                    cycles === e.cycles) begin
                    nPass++;
                end else begin
                    $display("FAIL outputs t=%0t got d%b g%b e%b c%0d pc%h ex%h ir%0d cy%0d want d%b g%b e%b c%0d pc%h ex%h ir%0d cy%0d",
                        $time, done, good, err, err_code, err_pc, err_expect_pc,
                        instret, cycles, e.done, e.good, e.err, e.code, e.errPc,
                        e.errExp, e.instret, e.cycles);
                end
            end
        end
    end

    initial begin : driver
        logic [63:0] pc, npc;
        int          wait_cnt;
        step(1, 0, 0, 0, 0, 0);
        // three sequential commits, then prove expect_pc = 0x8000000C
        ok(RPC, 32'h13, 0);
        ok(RPC + 4, 32'h13, 0);
        ok(RPC + 8, 32'h13, 0);
        ok(RPC + 12, 32'h13, 0);
        // wrong first PC
        step(1, 0, 0, 0, 0, 0);
        ok(RPC + 4, 32'h13, 0);
        idle(2);
        // good halt, ignored commit, then reset
        step(1, 0, 0, 0, 0, 0);
        ok(RPC, HALT, 0);
        step(0, 1, 32'h13, 64'h1234, 64'h1238, 0);
        step(1, 0, 0, 0, 0, 0);
        ok(RPC, 32'h13, 0);
        // bad halt
        step(1, 0, 0, 0, 0, 0);
        ok(RPC, HALT, 5);
        idle(2);
        // reset beats a mismatching commit
        step(1, 1, 32'h13, 64'h4444, 64'h4448, 0);
        idle(1);
        // watchdog expiry and commit in the expiry cycle
        step(1, 0, 0, 0, 0, 0);
        ok(RPC, 32'h13, 0);
        idle(WLIM - 1);
        ok(RPC + 4, 32'h13, 0);
        idle(WLIM);
        idle(2);
        // mismatch on a halt commit
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, HALT, RPC + 8, RPC + 12, 0);
        // randomized traffic
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(99) < ((mEnd != 0) ? 15 : 1)) begin
                step(1, $urandom_range(1), 32'h13, {$urandom, $urandom},
                     64'h0, 0);
            end else if ($urandom_range(99) < 75) begin
                pc = mExpect;
                if ($urandom_range(99) < 5)
                    pc = pc ^ {54'd0, 8'($urandom_range(1, 255)), 2'b00};
                npc = ($urandom_range(99) < 70) ? pc + 64'd4
                                                 : {$urandom, $urandom};
                step(0, 1, ($urandom_range(99) < 3) ? HALT : $urandom,
                     pc, npc, ($urandom_range(1) == 1) ? 64'd0 : 64'($urandom));
            end else begin
                step(0, 0, $urandom, {$urandom, $urandom}, 0, 0);
            end
        end
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb.size() > 0) begin
            nChecks++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
